// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage RISC-V pipeline: forwarding, load-use stall, branch flush, memory-wait freeze + watchdog.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        MemTimeout,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount,
  output logic [31:0] LoadUseCount
);

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_WAIT        = 2'd1,
    ST_TIMEOUT_ERR = 2'd2
  } state_t;

  // The RUN cycle that enters WAIT already counts as one not-ready cycle,
  // so the trip point in WAIT is two below TIMEOUT.
  localparam logic [7:0] TRIP = 8'(TIMEOUT - 2);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       lw_stall;
  logic       mem_wait;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_wait = (MemReqM && !MemReadyM) || (state == ST_TIMEOUT_ERR);

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mem_wait) begin
      // Freeze everything; a taken branch in Execute waits until the access completes.
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      StallF    = 1'b1;
      StallD    = 1'b1;
      StallE    = 1'b1;
      StallM    = 1'b1;
      FlushW    = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      StallF    = lw_stall;
      StallD    = lw_stall;
      FlushD    = PCSrcE;
      FlushE    = lw_stall || PCSrcE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      wait_cnt   <= 8'd0;
      MemTimeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          wait_cnt <= 8'd0;
          if (MemReqM && !MemReadyM) begin
            if (TIMEOUT == 1) begin
              state      <= ST_TIMEOUT_ERR;
              MemTimeout <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (MemReadyM) begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == TRIP) begin
            state      <= ST_TIMEOUT_ERR;
            MemTimeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_TIMEOUT_ERR: begin
          MemTimeout <= 1'b1;
        end
        default: begin
          state      <= ST_RUN;
          wait_cnt   <= 8'd0;
          MemTimeout <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCycles  <= 32'd0;
      FlushCount   <= 32'd0;
      LoadUseCount <= 32'd0;
    end else begin
      if (StallF) begin
        StallCycles <= StallCycles + 32'd1;
      end
      if (PCSrcE && !mem_wait) begin
        FlushCount <= FlushCount + 32'd1;
      end
      if (lw_stall && !mem_wait) begin
        LoadUseCount <= LoadUseCount + 32'd1;
      end
    end
  end
`else
  assign StallCycles  = 32'd0;
  assign FlushCount   = 32'd0;
  assign LoadUseCount = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (TIMEOUT=4); counter expectations follow HAZARD_PERF_EN.
module tb_hazard_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [31:0] StallCycles, FlushCount, LoadUseCount;
  logic [6:0]  ctl;

  int passed = 0;
  int total  = 0;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  hazard_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemTimeout(MemTimeout),
    .StallCycles(StallCycles), .FlushCount(FlushCount), .LoadUseCount(LoadUseCount)
  );

  // ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
    RdM = 5'd0; RdW = 5'd0; ResultSrcE0 = 1'b0; PCSrcE = 1'b0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    MemReqM = 1'b1; ResultSrcE0 = 1'b1; RdE = 5'd3; Rs1D = 5'd3; PCSrcE = 1'b1;
    RegWriteM = 1'b1; RdM = 5'd4; Rs1E = 5'd4; Rs2E = 5'd4;
    #1;
    total++; if (ctl !== 7'b0000111) $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0000111); else passed++;
    total++; if ({ForwardAE, ForwardBE} !== 4'b0000) $display("FAIL reset_fwd got=%b exp=%b", {ForwardAE, ForwardBE}, 4'b0000); else passed++;
    tick();
    total++; if (MemTimeout !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", MemTimeout); else passed++;
    total++; if ({StallCycles, FlushCount, LoadUseCount} !== 96'd0) $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", StallCycles, FlushCount, LoadUseCount); else passed++;
    reset = 1'b0;
    idle();
    #1;
    total++; if (ctl !== 7'b0000000) $display("FAIL idle_ctl got=%b exp=%b", ctl, 7'b0000000); else passed++;
    tick();
  endtask

  task automatic test_forwarding();
    RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd9;
    #1;
    total++; if (ForwardAE !== 2'b10) $display("FAIL fwd_mem_priority got=%b exp=10", ForwardAE); else passed++;
    total++; if (ForwardBE !== 2'b00) $display("FAIL fwd_b_nomatch got=%b exp=00", ForwardBE); else passed++;
    tick();
    RdM = 5'd0;
    #1;
    total++; if (ForwardAE !== 2'b01) $display("FAIL fwd_rdm_zero got=%b exp=01", ForwardAE); else passed++;
    tick();
    RdW = 5'd0;
    #1;
    total++; if (ForwardAE !== 2'b00) $display("FAIL fwd_rdw_zero got=%b exp=00", ForwardAE); else passed++;
    tick();
    RdM = 5'd9; RegWriteM = 1'b0; RdW = 5'd9; Rs2E = 5'd9;
    #1;
    total++; if (ForwardBE !== 2'b01) $display("FAIL fwd_b_wb_no_regwritem got=%b exp=01", ForwardBE); else passed++;
    tick();
    idle();
  endtask

  task automatic test_load_use();
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    total++; if (ctl !== 7'b1100010) $display("FAIL lu_stall got=%b exp=%b", ctl, 7'b1100010); else passed++;
    tick();
    ResultSrcE0 = 1'b0; RdE = 5'd0;
    #1;
    total++; if (ctl !== 7'b0000000) $display("FAIL lu_release got=%b exp=%b", ctl, 7'b0000000); else passed++;
    total++; if (LoadUseCount !== (PERF ? 32'd1 : 32'd0)) $display("FAIL lu_count got=%0d exp=%0d", LoadUseCount, PERF ? 1 : 0); else passed++;
    total++; if (StallCycles !== (PERF ? 32'd1 : 32'd0)) $display("FAIL lu_stallcycles got=%0d exp=%0d", StallCycles, PERF ? 1 : 0); else passed++;
    tick();
    ResultSrcE0 = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
    #1;
    total++; if (ctl !== 7'b0000000) $display("FAIL lu_x0 got=%b exp=%b", ctl, 7'b0000000); else passed++;
    tick();
    idle();
  endtask

  task automatic test_branch();
    PCSrcE = 1'b1;
    #1;
    total++; if (ctl !== 7'b0000110) $display("FAIL br_flush got=%b exp=%b", ctl, 7'b0000110); else passed++;
    tick();
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    #1;
    total++; if (ctl !== 7'b1100110) $display("FAIL br_with_lu got=%b exp=%b", ctl, 7'b1100110); else passed++;
    tick();
    idle();
    #1;
    total++; if (FlushCount !== (PERF ? 32'd2 : 32'd0)) $display("FAIL br_flushcount got=%0d exp=%0d", FlushCount, PERF ? 2 : 0); else passed++;
    total++; if (LoadUseCount !== (PERF ? 32'd2 : 32'd0)) $display("FAIL br_lucount got=%0d exp=%0d", LoadUseCount, PERF ? 2 : 0); else passed++;
    tick();
  endtask

  task automatic test_mem_wait();
    MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (ctl !== 7'b1111001) $display("FAIL mw_freeze cycle=%0d got=%b exp=%b", i, ctl, 7'b1111001); else passed++;
      tick();
    end
    MemReadyM = 1'b1;
    #1;
    total++; if (ctl !== 7'b0000110) $display("FAIL mw_ready_branch got=%b exp=%b", ctl, 7'b0000110); else passed++;
    tick();
    idle();
    #1;
    total++; if (StallCycles !== (PERF ? 32'd5 : 32'd0)) $display("FAIL mw_stallcycles got=%0d exp=%0d", StallCycles, PERF ? 5 : 0); else passed++;
    total++; if (FlushCount !== (PERF ? 32'd3 : 32'd0)) $display("FAIL mw_flushcount got=%0d exp=%0d", FlushCount, PERF ? 3 : 0); else passed++;
    tick();
    MemReqM = 1'b1; MemReadyM = 1'b1;
    #1;
    total++; if (ctl !== 7'b0000000) $display("FAIL mw_zero_wait got=%b exp=%b", ctl, 7'b0000000); else passed++;
    tick();
    idle();
  endtask

  task automatic test_watchdog();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (MemTimeout !== 1'b0) $display("FAIL wd_early cycle=%0d got=%b exp=0", i, MemTimeout); else passed++;
      tick();
    end
    MemReqM = 1'b0;
    #1;
    total++; if (MemTimeout !== 1'b1) $display("FAIL wd_trip got=%b exp=1", MemTimeout); else passed++;
    total++; if (ctl !== 7'b1111001) $display("FAIL wd_stall got=%b exp=%b", ctl, 7'b1111001); else passed++;
    tick();
    MemReadyM = 1'b1;
    #1;
    total++; if ({MemTimeout, ctl} !== 8'b11111001) $display("FAIL wd_sticky got=%b exp=%b", {MemTimeout, ctl}, 8'b11111001); else passed++;
    tick();
    total++; if (StallCycles !== (PERF ? 32'd11 : 32'd0)) $display("FAIL wd_stallcycles got=%0d exp=%0d", StallCycles, PERF ? 11 : 0); else passed++;
    reset = 1'b1;
    #1;
    total++; if (ctl !== 7'b0000111) $display("FAIL wd_reset_ctl got=%b exp=%b", ctl, 7'b0000111); else passed++;
    tick();
    reset = 1'b0;
    idle();
    #1;
    total++; if ({MemTimeout, ctl} !== 8'b00000000) $display("FAIL wd_after_reset got=%b exp=%b", {MemTimeout, ctl}, 8'b00000000); else passed++;
    total++; if (StallCycles !== 32'd0) $display("FAIL wd_counter_clear got=%0d exp=0", StallCycles); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    total++; if (ctl !== 7'b0000111) $display("FAIL rmw_reset_ctl got=%b exp=%b", ctl, 7'b0000111); else passed++;
    tick();
    reset = 1'b0;
    MemReqM = 1'b0;
    #1;
    total++; if ({MemTimeout, ctl} !== 8'b00000000) $display("FAIL rmw_no_residual got=%b exp=%b", {MemTimeout, ctl}, 8'b00000000); else passed++;
    total++; if ({StallCycles, FlushCount, LoadUseCount} !== 96'd0) $display("FAIL rmw_counters got=%0d/%0d/%0d exp=0/0/0", StallCycles, FlushCount, LoadUseCount); else passed++;
    tick();
    MemReqM = 1'b1;
    tick();
    tick();
    tick();
    total++; if (MemTimeout !== 1'b0) $display("FAIL rmw_waitcnt_cleared got=%b exp=0", MemTimeout); else passed++;
    tick();
    total++; if (MemTimeout !== 1'b1) $display("FAIL rmw_full_timeout got=%b exp=1", MemTimeout); else passed++;
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_watchdog();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
